// File: rtl/v_rom_sequencer_if.sv
// ROM read port and output handshake shared between the sequencer and its
// surroundings. master = sequencer side, slave = ROM/datapath side.
interface v_rom_sequencer_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 20
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              out_valid;
  logic [11:0]       out_data;
  logic              out_ready;

  modport master (
    output rom_en, rom_addr, out_valid, out_data,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_en, rom_addr, out_valid, out_data,
    output rom_data, out_ready
  );
endinterface

// File: rtl/v_rom_sequencer.sv
// Microcode sequencer: fetches 20-bit words from a registered-output ROM,
// decodes bits [15:0] and executes OUT / JMP / WAIT / LDC / HALT / NOP.
module v_rom_sequencer #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_flag,
  output logic                busy,
  output logic                done,
  v_rom_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OUT,
    S_WAIT
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        loop_cnt;
  logic [7:0]        wait_cnt;
  logic              done_q;
  logic              out_valid_q;
  logic [11:0]       out_data_q;

  // Instruction fields
  logic [3:0]        op;
  logic [3:0]        cond;
  logic [7:0]        imm8;
  logic [ADDR_W-1:0] target;
  logic              jmp_taken;
  logic              unused_hi;

  assign op        = bus.rom_data[15:12];
  assign cond      = bus.rom_data[11:8];
  assign imm8      = bus.rom_data[7:0];
  assign target    = bus.rom_data[ADDR_W-1:0];
  assign unused_hi = ^bus.rom_data[DATA_W-1:16];

  assign busy          = (state != S_IDLE);
  assign done          = done_q;
  assign bus.rom_en    = (state == S_FETCH);
  assign bus.rom_addr  = pc;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Jump condition evaluation for the word currently on rom_data
  always_comb begin
    jmp_taken = 1'b0;
    case (cond)
      4'd0:    jmp_taken = 1'b1;
      4'd1:    jmp_taken = (loop_cnt != 8'd0);
      4'd2:    jmp_taken = in_flag;
      4'd3:    jmp_taken = ~in_flag;
      default: jmp_taken = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      loop_cnt    <= '0;
      wait_cnt    <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          case (op)
            4'h0: begin
              out_data_q  <= bus.rom_data[11:0];
              out_valid_q <= 1'b1;
              state       <= S_OUT;
            end
            4'h2: begin
              pc <= jmp_taken ? target : pc + PC_ONE;
              if (cond == 4'd1 && jmp_taken) begin
                loop_cnt <= loop_cnt - 8'd1;
              end
              state <= S_FETCH;
            end
            4'h4: begin
              if (imm8 == 8'd0) begin
                pc    <= pc + PC_ONE;
                state <= S_FETCH;
              end else begin
                wait_cnt <= imm8;
                state    <= S_WAIT;
              end
            end
            4'h8: begin
              loop_cnt <= imm8;
              pc       <= pc + PC_ONE;
              state    <= S_FETCH;
            end
            4'hF: begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end
            default: begin
              pc    <= pc + PC_ONE;
              state <= S_FETCH;
            end
          endcase
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            pc          <= pc + PC_ONE;
            state       <= S_FETCH;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt == 8'd1) begin
            pc    <= pc + PC_ONE;
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v_rom_sequencer.sv
// Bench for v_rom_sequencer: an instruction-level program interpreter builds
// the expected per-cycle output trace, a compare process checks the DUT
// against it every cycle, and directed literal checks pin the interpreter.
module tb_v_rom_sequencer;

  localparam int unsigned LIM = 250;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        en;
    logic [5:0]  addr;
    logic        ov;
    logic [11:0] od;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic in_flag;
  logic busy;
  logic done;

  v_rom_sequencer_if #(.ADDR_W(6), .DATA_W(20)) bus ();

  v_rom_sequencer #(.ADDR_W(6), .DATA_W(20)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_flag (in_flag),
    .busy    (busy),
    .done    (done),
    .bus     (bus.master)
  );

  logic [19:0] rom [0:63];
  bit          rdy [0:255];
  exp_t        trace [$];
  exp_t        exp_q [$];
  logic [5:0]  m_pc;
  logic [7:0]  m_loop;
  logic [11:0] m_od;
  int          n_cmp;
  int          n_bad;
  int          xfers;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output ROM, one cycle of read latency
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
  end

  // Accepted output transfers
  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) xfers <= xfers + 1;
  end

  // Compare process: checks the DUT against the expected trace every cycle
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{busy, done, bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL trace t=%0t busy/done/en/addr/valid/data got %0b/%0b/%0b/%h/%0b/%h want %0b/%0b/%0b/%h/%0b/%h",
                   $time, a.busy, a.done, a.en, a.addr, a.ov, a.od,
                   e.busy, e.done, e.en, e.addr, e.ov, e.od);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input bit b, input bit d, input bit en,
                              input logic [5:0] ad, input bit v, input logic [11:0] od);
    mk = '{b, d, en, ad, v, od};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) rom[i] = 20'h0F000;
    for (int i = 0; i < 256; i++) rdy[i] = 1'b1;
  endtask

  // Interprets the program instruction by instruction from address 0
  task automatic build_trace();
    logic [19:0] w;
    int unsigned c;
    bit halted;
    bit taken;
    bit r;
    trace.delete();
    c = 0;
    halted = 0;
    m_pc = '0;
    while (!halted && c < LIM) begin
      trace.push_back(mk(1, 0, 1, m_pc, 0, m_od)); c++;
      w = rom[m_pc];
      trace.push_back(mk(1, 0, 0, m_pc, 0, m_od)); c++;
      case (w[15:12])
        4'h0: begin
          m_od = w[11:0];
          do begin
            trace.push_back(mk(1, 0, 0, m_pc, 1, m_od));
            r = rdy[c];
            c++;
          end while (!r && c < LIM);
          m_pc = m_pc + 6'd1;
        end
        4'h2: begin
          case (w[11:8])
            4'd0: taken = 1;
            4'd1: taken = (m_loop != 0);
            4'd2: taken = in_flag;
            4'd3: taken = !in_flag;
            default: taken = 0;
          endcase
          if (w[11:8] == 4'd1 && taken) m_loop = m_loop - 8'd1;
          m_pc = taken ? w[5:0] : m_pc + 6'd1;
        end
        4'h4: begin
          for (int unsigned k = 0; k < w[7:0]; k++) begin
            trace.push_back(mk(1, 0, 0, m_pc, 0, m_od)); c++;
          end
          m_pc = m_pc + 6'd1;
        end
        4'h8: begin
          m_loop = w[7:0];
          m_pc = m_pc + 6'd1;
        end
        4'hF: halted = 1;
        default: m_pc = m_pc + 6'd1;
      endcase
    end
    if (halted) begin
      trace.push_back(mk(0, 1, 0, m_pc, 0, m_od));
      trace.push_back(mk(0, 0, 0, m_pc, 0, m_od));
      trace.push_back(mk(0, 0, 0, m_pc, 0, m_od));
    end
  endtask

  // Pulse start and drive out_ready per cycle while the trace is checked
  task automatic run_prog();
    build_trace();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q = trace;
    for (int c = 0; c < trace.size(); c++) begin
      bus.out_ready = rdy[c];
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
  endtask

  function automatic int nth_en(input int n);
    int seen;
    seen = 0;
    nth_en = -1;
    for (int i = 0; i < trace.size(); i++) begin
      if (trace[i].en) begin
        seen++;
        if (seen == n) return i;
      end
    end
  endfunction

  function automatic int count_valid();
    count_valid = 0;
    for (int i = 0; i < trace.size(); i++) if (trace[i].ov) count_valid++;
  endfunction

  initial begin
    int x0;
    int idx;
    n_cmp = 0;
    n_bad = 0;
    xfers = 0;
    m_loop = '0;
    m_od = '0;
    in_flag = 1'b0;
    bus.out_ready = 1'b0;
    clear_prog();

    // Reset held two cycles with start asserted
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rom_en", bus.rom_en, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_addr", bus.rom_addr, 0);
    check("rst_data", bus.out_data, 0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // OUT held under back-pressure
    clear_prog();
    rom[0] = 20'h00ABC;
    rom[1] = 20'h0F000;
    for (int i = 2; i < 7; i++) rdy[i] = 1'b0;
    x0 = xfers;
    run_prog();
    check("bp_model_valid_cycles", count_valid(), 6);
    check("bp_model_fetch1", nth_en(2), 8);
    check("bp_xfers", xfers - x0, 1);

    // Loop: four OUT transfers then HALT
    clear_prog();
    rom[0] = 20'h08003;
    rom[1] = 20'h00001;
    rom[2] = 20'h02101;
    rom[3] = 20'h0F000;
    x0 = xfers;
    run_prog();
    check("loop_model_valid", count_valid(), 4);
    check("loop_xfers", xfers - x0, 4);
    check("loop_busy_after", busy, 0);

    // WAIT 5 and WAIT 0 timing
    clear_prog();
    rom[0] = 20'h04005;
    run_prog();
    check("wait5_gap", nth_en(2), 7);
    clear_prog();
    rom[0] = 20'h04000;
    run_prog();
    check("wait0_gap", nth_en(2), 2);

    // Conditional jump on in_flag
    clear_prog();
    rom[0] = 20'h0223A;
    in_flag = 1'b1;
    run_prog();
    check("jmp_flag1_addr", trace[2].addr, 6'h3A);
    in_flag = 1'b0;
    run_prog();
    check("jmp_flag0_addr", trace[2].addr, 6'h01);

    // pc wrap from 63 to 0
    clear_prog();
    rom[0]  = 20'h02102;
    rom[1]  = 20'h0203E;
    rom[62] = 20'h08001;
    rom[63] = 20'h01000;
    rom[2]  = 20'h0F000;
    run_prog();
    idx = -1;
    for (int i = 0; i < trace.size(); i++) begin
      if (idx < 0 && trace[i].en && trace[i].addr == 6'd63) idx = i;
    end
    check("wrap_seen63", idx >= 0, 1);
    if (idx >= 0) check("wrap_next_addr", trace[idx + 2].addr, 0);

    // Reset during OUT drops the pending word
    clear_prog();
    rom[0] = 20'h00555;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstout_valid_before", bus.out_valid, 1);
    check("rstout_data_before", bus.out_data, 12'h555);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstout_valid_after", bus.out_valid, 0);
    check("rstout_busy_after", busy, 0);
    check("rstout_addr_after", bus.rom_addr, 0);
    rst = 1'b0;
    m_loop = '0;
    m_od = '0;
    @(posedge clk); #1;
    check("rstout_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
